pad_sequencer: RTL and testbench
================================

PAD_SEQUENCER -- requirements
Module: pad_sequencer

Interface
REQ-001 SHALL have parameter RATE_WORDS, default 34, meaning sponge rate in 32-bit words (34 = 1088-bit rate); legal range 2..42.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port in, input, 32, message word; byte 0 is in[31:24].
REQ-005 SHALL have port in_ready, input, 1, in/is_last/byte_num valid this cycle.
REQ-006 SHALL have port is_last, input, 1, current word is the final message word.
REQ-007 SHALL have port byte_num, input, 2, number of valid message bytes in the final word (0..3); ignored unless is_last.
REQ-008 SHALL have port buffer_full, output, 1, high when a word offered this cycle will not be accepted.
REQ-009 SHALL have port out, output, 32*RATE_WORDS, assembled block; word 0 in the MSBs.
REQ-010 SHALL have port out_ready, output, 1, out holds a complete block.
REQ-011 SHALL have port f_ack, input, 1, permutation consumer has taken the block.

Function
REQ-012 SHALL implement states FILL, PAD and FULL.
REQ-013 FILL: a word is accepted when in_ready=1 and buffer_full=0, shifted into the block register at the LSB end, and the word counter increments.
REQ-014 A non-last word SHALL be stored unchanged; a last word SHALL be stored as padder1(in, byte_num): valid bytes kept, byte byte_num set to 8'h06, lower bytes zero.
REQ-015 Last word accepted with counter < RATE_WORDS-1 -> PAD; with counter = RATE_WORDS-1 -> FULL.
REQ-016 Non-last word filling slot RATE_WORDS-1 -> FULL, with the block marked non-final.
REQ-017 PAD: one all-zero word shifted in per cycle; in_ready ignored; -> FULL when the last slot is written.
REQ-018 out_ready SHALL rise the cycle after the last slot is written and hold until f_ack.
REQ-019 A final block SHALL present its last byte, out[7:0], ORed with 8'h80; a non-final block SHALL present it unmodified.
REQ-020 buffer_full SHALL be 1 in PAD and FULL and 0 in FILL.
REQ-021 FULL with f_ack=1: counter cleared, out_ready low next cycle, state -> FILL; the next message or block starts in the following cycle.
REQ-022 f_ack in FILL or PAD SHALL be ignored.
REQ-023 in_ready offered in the same cycle as f_ack in FULL SHALL be ignored.
REQ-024 Counter SHALL never exceed RATE_WORDS-1 and SHALL wrap to 0 only via f_ack.

Reset
REQ-025 rst_n=0 SHALL immediately force state FILL, counter 0, final flag 0, block register 0, out_ready 0 and buffer_full 0, including mid-fill or mid-pad.
REQ-026 After rst_n deasserts, the first accepted word SHALL occupy slot 0.

Structure
REQ-027 A shared package SHALL hold PAD_BYTE = 8'h06, FINAL_BYTE = 8'h80, the state encoding and the default RATE_WORDS.
REQ-028 SHALL instantiate exactly one padder1 sub-module on the in/byte_num path; all other logic is inline.

Verification
REQ-029 The bench SHALL run with RATE_WORDS = 4 (128-bit out) and cover the following scenarios.
REQ-030 Words 11111111, 22222222, then 33333333 with is_last=1 and byte_num=2 -> one PAD cycle, then out = 11111111_22222222_33330600_00000080 and out_ready=1.
REQ-031 Four AAAAAAAA words (non-last) -> out = AAAAAAAA x4 with no 80 in out[7:0]; after f_ack, a last word with byte_num=0 -> out = 06000000_00000000_00000000_00000080.
REQ-032 Slots 0..2 filled, then DEADBEEF with is_last=1 and byte_num=3 in slot 3 -> out[31:0] = DEADBE86 with no PAD cycles.
REQ-033 Block held with f_ack=0 for 10 cycles while in_ready pulses -> buffer_full=1, out stable, no words lost; f_ack -> out_ready low next cycle.
REQ-034 rst_n pulsed low after 2 words -> out_ready=0, out=0; the next 4 words form a fresh block starting at slot 0.

Source files
------------

// File: rtl/pad_sequencer_pkg.sv
// Shared constants and state encoding for the sponge block padder.
// Imported by the padder1 datapath and the sequencer top.
package pad_sequencer_pkg;

  localparam int RATE_WORDS_DEF = 34;

  localparam logic [7:0] PAD_BYTE   = 8'h06;
  localparam logic [7:0] FINAL_BYTE = 8'h80;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    FULL = 2'd2
  } state_t;

endpackage

// File: rtl/pad_sequencer_padder1.sv
// Pads a final message word: keeps the valid bytes, places PAD_BYTE
// after them and zeroes the rest.
module pad_sequencer_padder1
  import pad_sequencer_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_byte_num,
  output logic [31:0] o_word
);

  always_comb begin
    o_word = '0;
    unique case (1'b1)
      (i_byte_num == 2'd0): o_word = {PAD_BYTE, 24'h0};
      (i_byte_num == 2'd1): o_word = {i_word[31:24], PAD_BYTE, 16'h0};
      (i_byte_num == 2'd2): o_word = {i_word[31:16], PAD_BYTE, 8'h0};
      (i_byte_num == 2'd3): o_word = {i_word[31:8], PAD_BYTE};
      default:              o_word = '0;
    endcase
  end

endmodule

// File: rtl/pad_sequencer.sv
// Assembles message words into one sponge-rate block, padding the
// final word and zero-filling the remaining slots.
module pad_sequencer
  import pad_sequencer_pkg::*;
#(
  parameter int RATE_WORDS = RATE_WORDS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             in,
  input  logic                    in_ready,
  input  logic                    is_last,
  input  logic [1:0]              byte_num,
  output logic                    buffer_full,
  output logic [32*RATE_WORDS-1:0] out,
  output logic                    out_ready,
  input  logic                    f_ack
);

  localparam int W  = 32 * RATE_WORDS;
  localparam int CW = $clog2(RATE_WORDS);
  localparam logic [CW-1:0] LAST = CW'(RATE_WORDS - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_final;
  logic          r_out_ready;
  logic [W-1:0]  r_blk;

  logic [31:0]   w_padded;
  logic [31:0]   w_word;

  pad_sequencer_padder1 u_padder1 (
    .i_word     (in),
    .i_byte_num (byte_num),
    .o_word     (w_padded)
  );

  assign w_word      = is_last ? w_padded : in;
  assign buffer_full = (r_state != FILL);
  assign out_ready   = r_out_ready;
  assign out = {r_blk[W-1:8],
                r_blk[7:0] | (r_final ? FINAL_BYTE : 8'h00)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_cnt       <= '0;
      r_final     <= 1'b0;
      r_out_ready <= 1'b0;
      r_blk       <= '0;
    end else begin
      unique case (r_state)
        FILL: begin
          if (in_ready) begin
            r_blk <= {r_blk[W-33:0], w_word};
            if (is_last)
              r_final <= 1'b1;
            if (r_cnt == LAST) begin
              r_state     <= FULL;
              r_out_ready <= 1'b1;
            end else begin
              r_cnt   <= r_cnt + CW'(1);
              r_state <= is_last ? PAD : FILL;
            end
          end
        end
        PAD: begin
          r_blk <= {r_blk[W-33:0], 32'h0};
          if (r_cnt == LAST) begin
            r_state     <= FULL;
            r_out_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        FULL: begin
          // Any word offered alongside f_ack is dropped on purpose.
          if (f_ack) begin
            r_cnt       <= '0;
            r_final     <= 1'b0;
            r_out_ready <= 1'b0;
            r_state     <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_sequencer.sv
// Directed bench for pad_sequencer with a 4-word rate.
// Expected blocks are hand-computed constants.
module tb_pad_sequencer;

  localparam int RW = 4;

  logic           clk;
  logic           rst_n;
  logic [31:0]    din;
  logic           in_ready;
  logic           is_last;
  logic [1:0]     byte_num;
  logic           buffer_full;
  logic [127:0]   dout;
  logic           out_ready;
  logic           f_ack;

  int n_checks;
  int n_fail;

  pad_sequencer #(.RATE_WORDS(RW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (din),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .buffer_full (buffer_full),
    .out         (dout),
    .out_ready   (out_ready),
    .f_ack       (f_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w,
                      input logic last,
                      input logic [1:0] bn);
    int guard;
    guard = 0;
    while (buffer_full && guard < 20) begin
      tick();
      guard++;
    end
    if (buffer_full)
      check("send_timeout", 1, 0);
    din      = w;
    is_last  = last;
    byte_num = bn;
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    is_last  = 1'b0;
    byte_num = 2'd0;
  endtask

  task automatic wait_block(output int cyc);
    cyc = 0;
    while (!out_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!out_ready)
      check("block_timeout", 0, 1);
  endtask

  task automatic ack();
    f_ack = 1'b1;
    tick();
    f_ack = 1'b0;
  endtask

  int cyc;
  logic [127:0] held;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    din      = '0;
    in_ready = 1'b0;
    is_last  = 1'b0;
    byte_num = 2'd0;
    f_ack    = 1'b0;
    #12;
    check("rst_out", dout, 128'h0);
    check("rst_ordy", {127'h0, out_ready}, 128'h0);
    check("rst_bfull", {127'h0, buffer_full}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Short message: one zero PAD slot
    send(32'h11111111, 1'b0, 2'd0);
    send(32'h22222222, 1'b0, 2'd0);
    send(32'h33333333, 1'b1, 2'd2);
    check("pad_bfull", {127'h0, buffer_full}, 128'h1);
    check("pad_ordy0", {127'h0, out_ready}, 128'h0);
    tick();
    check("pad_ordy1", {127'h0, out_ready}, 128'h1);
    check("pad_out", dout,
          128'h11111111_22222222_33330600_00000080);
    ack();
    check("ack_ordy", {127'h0, out_ready}, 128'h0);
    check("ack_bfull", {127'h0, buffer_full}, 128'h0);

    // Non-final full block, then an empty final word
    for (int i = 0; i < RW; i++)
      send(32'hAAAAAAAA, 1'b0, 2'd0);
    check("nf_ordy", {127'h0, out_ready}, 128'h1);
    check("nf_out", dout, {4{32'hAAAAAAAA}});
    ack();
    send(32'hFFFFFFFF, 1'b1, 2'd0);
    wait_block(cyc);
    check("bn0_pad_cycles", 128'(cyc), 128'd3);
    check("bn0_out", dout,
          128'h06000000_00000000_00000000_00000080);
    ack();

    // Final word lands in the last slot
    send(32'h01010101, 1'b0, 2'd0);
    send(32'h02020202, 1'b0, 2'd0);
    send(32'h03030303, 1'b0, 2'd0);
    send(32'hDEADBEEF, 1'b1, 2'd3);
    check("last_slot_ordy", {127'h0, out_ready}, 128'h1);
    check("last_slot_lo", {96'h0, dout[31:0]}, 128'hDEADBE86);
    check("last_slot_out", dout,
          128'h01010101_02020202_03030303_DEADBE86);

    // Hold the block while the producer keeps offering words
    held = dout;
    for (int i = 0; i < 10; i++) begin
      din      = 32'h55555555;
      in_ready = i[0];
      tick();
      if (i == 4 || i == 9) begin
        check("hold_bfull", {127'h0, buffer_full}, 128'h1);
        check("hold_out", dout, held);
      end
    end
    din      = 32'h77777777;
    in_ready = 1'b1;
    f_ack    = 1'b1;
    tick();
    in_ready = 1'b0;
    f_ack    = 1'b0;
    check("hold_ack_ordy", {127'h0, out_ready}, 128'h0);
    send(32'h10101010, 1'b0, 2'd0);
    send(32'h20202020, 1'b0, 2'd0);
    send(32'h30303030, 1'b0, 2'd0);
    send(32'h40404040, 1'b0, 2'd0);
    check("after_hold_out", dout,
          128'h10101010_20202020_30303030_40404040);
    ack();

    // Reset mid-fill
    send(32'hCAFEF00D, 1'b0, 2'd0);
    send(32'hBADC0FFE, 1'b0, 2'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_out", dout, 128'h0);
    check("midrst_ordy", {127'h0, out_ready}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(32'hA1A1A1A1, 1'b0, 2'd0);
    send(32'hB2B2B2B2, 1'b0, 2'd0);
    send(32'hC3C3C3C3, 1'b0, 2'd0);
    check("midrst_not_full", {127'h0, out_ready}, 128'h0);
    send(32'hD4D4D4D4, 1'b0, 2'd0);
    check("midrst_block", dout,
          128'hA1A1A1A1_B2B2B2B2_C3C3C3C3_D4D4D4D4);
    ack();

    // Reset mid-pad
    send(32'h12345678, 1'b1, 2'd1);
    check("mp_bfull", {127'h0, buffer_full}, 128'h1);
    rst_n = 1'b0;
    #1;
    check("mp_rst_bfull", {127'h0, buffer_full}, 128'h0);
    check("mp_rst_out", dout, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(32'h9ABCDEF0, 1'b1, 2'd1);
    wait_block(cyc);
    check("mp_block", dout,
          128'h9A060000_00000000_00000000_00000080);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
